// File: rtl/pau_pkg.sv
// Shared types and constants for the posit adder scheduler.
// Holds the FSM states, response flag bit positions and the NaR code.
package pau_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        RESP
    } state_t;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_INF     = 1;
    localparam int FLAG_TIMEOUT = 2;

    localparam logic [15:0] NAR = 16'h8000;

endpackage

// File: rtl/pau_scheduler_if.sv
// Requester, response and adder-side signals of the scheduler.
// slave is the scheduler view, master is the environment view.
interface pau_scheduler_if;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][15:0] req_a;
    logic [1:0][15:0] req_b;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [15:0]      rsp_data;
    logic [2:0]       rsp_flags;
    logic             pau_start;
    logic [15:0]      pau_in1;
    logic [15:0]      pau_in2;
    logic             pau_done;
    logic [15:0]      pau_out;
    logic             pau_inf;
    logic             pau_zero;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        input  pau_done, pau_out, pau_inf, pau_zero,
        output req_ready, rsp_valid, rsp_data, rsp_flags,
        output pau_start, pau_in1, pau_in2
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        output pau_done, pau_out, pau_inf, pau_zero,
        input  req_ready, rsp_valid, rsp_data, rsp_flags,
        input  pau_start, pau_in1, pau_in2
    );

endinterface

// File: rtl/pau_rr_arb.sv
// Two-way round-robin arbiter producing a one-hot grant.
// On contention the requester other than last_grant wins.
module pau_rr_arb (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // pick the winner from the request pattern and the last owner
    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (valid == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
            (valid == 2'b01): grant = 2'b01;
            (valid == 2'b10): grant = 2'b10;
            default:          grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/pau_scheduler.sv
// Shares one posit adder between two requesters, one op at a time.
// A stalled adder is cut off after TIMEOUT_CYCLES and answered with NaR.
module pau_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    pau_scheduler_if.slave bus
);
    import pau_pkg::*;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic        last_grant_q;
    logic        owner_q;
    logic [1:0]  grant;
    logic [1:0]  ready;
    logic [9:0]  cnt_q;
    logic [15:0] in1_q;
    logic [15:0] in2_q;
    logic [15:0] data_q;
    logic [2:0]  flags_q;
    logic        accept;
    logic        done_hit;
    logic        tmo_hit;
    logic        rsp_hs;

    pau_rr_arb u_arb (
        .valid      (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign ready = (state_q == IDLE && !rst) ? grant : 2'b00;

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state_q == RESP) ? (2'b01 << owner_q) : 2'b00;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_flags = flags_q;
    assign bus.pau_start = (state_q == START);
    assign bus.pau_in1   = in1_q;
    assign bus.pau_in2   = in2_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state and the per-cycle events that drive the datapath
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        done_hit = 1'b0;
        tmo_hit  = 1'b0;
        rsp_hs   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|(bus.req_valid & ready)) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: state_d = BUSY;
            BUSY: begin
                if (bus.pau_done) begin
                    done_hit = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[owner_q]) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // operand latch, busy counter, result capture and grant history
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            data_q       <= '0;
            flags_q      <= '0;
        end else begin
            cnt_q <= (state_q == BUSY) ? cnt_q + 10'd1 : '0;
            if (accept) begin
                owner_q <= grant[1];
                in1_q   <= bus.req_a[grant[1]];
                in2_q   <= bus.req_b[grant[1]];
            end
            if (done_hit) begin
                data_q             <= bus.pau_out;
                flags_q            <= '0;
                flags_q[FLAG_INF]  <= bus.pau_inf;
                flags_q[FLAG_ZERO] <= bus.pau_zero;
            end
            if (tmo_hit) begin
                data_q                <= NAR;
                flags_q               <= '0;
                flags_q[FLAG_TIMEOUT] <= 1'b1;
            end
            if (rsp_hs) last_grant_q <= owner_q;
        end
    end

endmodule

// File: tb/tb_pau_scheduler.sv
// Scoreboard bench for pau_scheduler with a behavioural adder model.
// Expected responses are queued at acceptance and checked by a monitor.
module tb_pau_scheduler;

    localparam int TMO = 8;

    typedef struct {
        int          owner;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic [2:0]  flags;
        int          lat;
    } exp_t;

    typedef struct {
        int          k;
        logic [15:0] out;
        logic        inf;
        logic        zero;
    } pop_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pau_scheduler_if bif ();

    pau_scheduler #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    exp_t exp_q[$];
    pop_t pau_q[$];
    int   grant_log[$];

    logic [15:0] cur_a[2];
    logic [15:0] cur_b[2];
    logic [15:0] cur_out[2];
    logic        cur_inf[2];
    logic        cur_zero[2];
    int          cur_k[2];
    bit          pend[2];
    bit          accepted[2];

    bit          outstanding = 0;
    bit          resp_active = 0;
    bit          start_seen = 0;
    int          last_owner = 1;
    int          acc_cyc = 0;
    int          cyc = 0;
    logic [15:0] held_data;
    logic [2:0]  held_flags;
    logic [1:0]  held_valid;

    int          n_chk = 0;
    int          n_fail = 0;
    int          rsp_mode = 0;
    logic [1:0]  rsp_force = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // one clock step: retire accepted requests, drive rsp_ready
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (accepted[i]) begin
                accepted[i] = 0;
                pend[i] = 0;
                bif.req_valid[i] = 1'b0;
            end
        end
        case (rsp_mode)
            0:       bif.rsp_ready = 2'b11;
            1:       bif.rsp_ready = 2'($urandom);
            default: bif.rsp_ready = rsp_force;
        endcase
    endtask

    task automatic new_op(input int i, input logic [15:0] a,
                          input logic [15:0] b, input int k,
                          input logic [15:0] out, input logic inf,
                          input logic zero);
        cur_a[i] = a;
        cur_b[i] = b;
        cur_k[i] = k;
        cur_out[i] = out;
        cur_inf[i] = inf;
        cur_zero[i] = zero;
        bif.req_a[i] = a;
        bif.req_b[i] = b;
        bif.req_valid[i] = 1'b1;
        pend[i] = 1;
    endtask

    task automatic rand_op(input int i);
        int r;
        int k;
        r = $urandom_range(0, 11);
        if (r <= 7)       k = $urandom_range(1, TMO);
        else if (r == 8)  k = TMO;
        else if (r == 9)  k = TMO + 1;
        else if (r == 10) k = TMO + 2;
        else              k = 0;
        new_op(i, 16'($urandom), 16'($urandom), k, 16'($urandom),
               1'($urandom), 1'($urandom));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((pend[0] || pend[1] || outstanding) && n < budget) begin
            step();
            n++;
        end
        check("drain", 32'(pend[0] || pend[1] || outstanding), 0);
    endtask

    // adder model: done pulse k cycles after start (k=0: never)
    initial begin
        pop_t p;
        bif.pau_done = 1'b0;
        bif.pau_out = '0;
        bif.pau_inf = 1'b0;
        bif.pau_zero = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.pau_start && !rst && pau_q.size() > 0) begin
                p = pau_q.pop_front();
                if (p.k > 0) begin
                    repeat (p.k) @(posedge clk);
                    #1;
                    bif.pau_done = 1'b1;
                    bif.pau_out = p.out;
                    bif.pau_inf = p.inf;
                    bif.pau_zero = p.zero;
                    @(posedge clk);
                    #1;
                    bif.pau_done = 1'b0;
                    bif.pau_out = 16'($urandom);
                    bif.pau_inf = 1'($urandom);
                    bif.pau_zero = 1'($urandom);
                end
            end
        end
    end

    // monitor: acceptance bookkeeping and response checking
    initial begin
        exp_t       e;
        int         w;
        int         ew;
        logic [1:0] acc;
        logic [1:0] oh;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                pau_q.delete();
                outstanding = 0;
                resp_active = 0;
                start_seen = 0;
                last_owner = 1;
            end else if (outstanding) begin
                e = exp_q[0];
                check("ready_busy", 32'(bif.req_ready), 0);
                if (bif.pau_start) begin
                    check("start_once", 32'(start_seen), 0);
                    check("start_cyc", cyc, acc_cyc + 1);
                    check("pau_in1", bif.pau_in1, e.a);
                    check("pau_in2", bif.pau_in2, e.b);
                    start_seen = 1;
                end
                if (bif.rsp_valid != 2'b00) begin
                    if (!resp_active) begin
                        oh = 2'(1 << e.owner);
                        check("rsp_valid", 32'(bif.rsp_valid), 32'(oh));
                        check("rsp_data", bif.rsp_data, e.data);
                        check("rsp_flags", 32'(bif.rsp_flags), 32'(e.flags));
                        check("latency", cyc - acc_cyc, 2 + e.lat);
                        check("started", 32'(start_seen), 1);
                        check("in1_stable", bif.pau_in1, e.a);
                        check("in2_stable", bif.pau_in2, e.b);
                        held_data = bif.rsp_data;
                        held_flags = bif.rsp_flags;
                        held_valid = bif.rsp_valid;
                        resp_active = 1;
                    end else begin
                        check("hold_valid", 32'(bif.rsp_valid), 32'(held_valid));
                        check("hold_data", bif.rsp_data, held_data);
                        check("hold_flags", 32'(bif.rsp_flags), 32'(held_flags));
                    end
                    if (bif.rsp_ready[e.owner]) begin
                        last_owner = e.owner;
                        void'(exp_q.pop_front());
                        outstanding = 0;
                        resp_active = 0;
                        start_seen = 0;
                    end
                end else if (resp_active) begin
                    check("rsp_dropped", 32'(bif.rsp_valid), 32'(held_valid));
                end
            end else begin
                check("idle_rsp_valid", 32'(bif.rsp_valid), 0);
                check("idle_start", 32'(bif.pau_start), 0);
                check("ready_bits", 32'($countones(bif.req_ready) <= 1), 1);
                if (bif.req_valid != 2'b00)
                    check("idle_ready", 32'(|bif.req_ready), 1);
                acc = bif.req_valid & bif.req_ready;
                if (acc != 2'b00) begin
                    w = acc[1] ? 1 : 0;
                    if (bif.req_valid == 2'b11) ew = 1 - last_owner;
                    else                        ew = bif.req_valid[1] ? 1 : 0;
                    check("rr_grant", w, ew);
                    e.owner = w;
                    e.a = cur_a[w];
                    e.b = cur_b[w];
                    if (cur_k[w] >= 1 && cur_k[w] <= TMO) begin
                        e.data = cur_out[w];
                        e.flags = {1'b0, cur_inf[w], cur_zero[w]};
                        e.lat = cur_k[w];
                    end else begin
                        e.data = 16'h8000;
                        e.flags = 3'b100;
                        e.lat = TMO;
                    end
                    exp_q.push_back(e);
                    pau_q.push_back('{cur_k[w], cur_out[w], cur_inf[w],
                                      cur_zero[w]});
                    grant_log.push_back(w);
                    outstanding = 1;
                    start_seen = 0;
                    acc_cyc = cyc;
                    accepted[w] = 1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // directed scenarios followed by a randomized run
    initial begin
        int issued;
        int n;
        rst = 1'b1;
        bif.req_valid = 2'b11;
        bif.req_a = '0;
        bif.req_b = '0;
        bif.rsp_ready = 2'b00;
        pend[0] = 0;
        pend[1] = 0;
        accepted[0] = 0;
        accepted[1] = 0;
        for (int i = 0; i < 2; i++) new_op(i, '0, '0, 1, '0, 0, 0);
        pend[0] = 0;
        pend[1] = 0;

        repeat (3) step();
        @(negedge clk);
        check("rst_req_ready", 32'(bif.req_ready), 0);
        check("rst_rsp_valid", 32'(bif.rsp_valid), 0);
        check("rst_pau_start", 32'(bif.pau_start), 0);
        check("rst_pau_in1", bif.pau_in1, 0);
        check("rst_pau_in2", bif.pau_in2, 0);
        check("rst_rsp_data", bif.rsp_data, 0);
        check("rst_rsp_flags", 32'(bif.rsp_flags), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bif.req_valid = 2'b00;

        grant_log.delete();
        issued = 0;
        n = 0;
        while (issued < 4 && n < 200) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && issued < 4) begin
                    new_op(i, 16'($urandom), 16'($urandom), 1,
                           16'($urandom), 0, 0);
                    issued++;
                end
            end
            n++;
        end
        wait_idle(200);
        check("rr_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size())
                check("rr_order", grant_log[i], i % 2);
        end

        step();
        new_op(0, 16'h4000, 16'h4000, 3, 16'h5000, 0, 0);
        wait_idle(50);

        step();
        new_op(1, 16'h1234, 16'h5678, 0, 16'h0, 0, 0);
        wait_idle(50);

        step();
        new_op(0, 16'h0011, 16'h0022, TMO, 16'h0000, 0, 1);
        wait_idle(50);

        rsp_mode = 2;
        rsp_force = 2'b10;
        step();
        new_op(0, 16'hAAAA, 16'h5555, 2, 16'hBEEF, 1, 0);
        n = 0;
        while (!bif.rsp_valid[0] && n < 30) begin
            step();
            n++;
        end
        check("hold_seen", 32'(bif.rsp_valid[0]), 1);
        new_op(1, 16'h0F0F, 16'hF0F0, 1, 16'h7777, 0, 0);
        repeat (5) step();
        check("hold_still_valid", 32'(bif.rsp_valid), 32'b01);
        check("hold_ready_low", 32'(bif.req_ready), 0);
        rsp_force = 2'b11;
        wait_idle(50);
        rsp_mode = 0;

        step();
        new_op(0, 16'h3000, 16'h3000, 6, 16'h4000, 0, 0);
        n = 0;
        while (!start_seen && n < 20) begin
            step();
            n++;
        end
        check("rst_op_started", 32'(start_seen), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        check("rst_op_abandoned", 32'(outstanding), 0);
        new_op(1, 16'h2222, 16'h3333, 2, 16'h4444, 0, 0);
        wait_idle(50);

        rsp_mode = 1;
        issued = 0;
        n = 0;
        while (issued < 40 && n < 5000) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && issued < 40 && $urandom_range(0, 2) == 0) begin
                    rand_op(i);
                    issued++;
                end
            end
            n++;
        end
        check("rand_issued", issued, 40);
        wait_idle(500);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
